// File: rtl/uncache_axi_bridge_if.sv
// rtl/uncache_axi_bridge_if.sv - AXI3 master-side bus bundle for the uncache bridge
interface uncache_axi_bridge_if;
  // read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [3:0]  rid;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncache_axi_bridge.sv
// rtl/uncache_axi_bridge.sv - single-outstanding AXI3 master for uncached word/sub-word accesses
module uncache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'b0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_en,
  input  logic                 req_wen,
  input  logic [3:0]           req_sel,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 refresh,
  output logic [31:0]          rdata,
  output logic                 resp_err,
  uncache_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_DONE,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;

  // IDs are fixed and there is only ever one transaction in flight, so the
  // returned rid/bid carry no information for us.
  logic unused_ids;
  assign unused_ids = ^{axi.rid, axi.bid};

  // Byte-lane pattern to AXI size; irregular patterns fall back to a full word.
  function automatic logic [2:0] size_of(input logic [3:0] sel);
    logic [2:0] sz;
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 3'd0;
      4'b0011, 4'b1100:                   sz = 3'd1;
      default:                            sz = 3'd2;
    endcase
    return sz;
  endfunction

  // State and request/response registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and capture logic for one request at a time.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_en) begin
          addr_d    = req_addr;
          sel_d     = req_sel;
          wdata_d   = req_wdata;
          size_d    = size_of(req_sel);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? S_WREQ : S_RADDR;
        end
      end
      S_RADDR: begin
        if (axi.arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (axi.rvalid && axi.rlast) begin
          rdata_d = axi.rdata_axi;
          resp_d  = axi.rresp;
          state_d = S_DONE;
        end
      end
      S_WREQ: begin
        // Each channel retires on its own handshake; ready seen after the
        // channel already retired is harmless because the flag is sticky.
        aw_done_d = aw_done_q | axi.awready;
        w_done_d  = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (axi.bvalid) begin
          resp_d  = axi.bresp;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign refresh  = (state_q == S_DONE);
  assign resp_err = (state_q == S_DONE) && (resp_q != 2'b00);
  assign rdata    = rdata_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (state_q == S_RADDR);
  assign axi.rready  = (state_q == S_RDATA);

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = size_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = (state_q == S_WREQ) && !aw_done_q;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = sel_q;
  assign axi.wvalid  = (state_q == S_WREQ) && !w_done_q;
  assign axi.wlast   = axi.wvalid;
  assign axi.bready  = (state_q == S_WRESP);

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// tb/tb_uncache_axi_bridge.sv - scoreboard bench for uncache_axi_bridge
module tb_uncache_axi_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0;
  logic        req_wen = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        refresh;
  logic [31:0] rdata;
  logic        resp_err;

  uncache_axi_bridge_if axi();

  uncache_axi_bridge #(.AXI_ID(4'b0001)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .refresh(refresh), .rdata(rdata),
    .resp_err(resp_err), .axi(axi)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit rd; logic [31:0] data; bit err; int at; } rsp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [2:0] size; } adr_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } wdt_t;
  rsp_t rsp_q[$];
  adr_t adr_q[$];
  wdt_t wdt_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // slave knobs
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_resp = 2'b00;

  // AXI slave model: readies/valids updated just after each clock edge
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rid = 4'd1; axi.rresp = 0;
    axi.rdata_axi = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 4'd1;
    axi.bresp = 0;
    forever begin
      @(posedge clk); #1;
      if (axi.arvalid === 1'b1) begin
        if (ar_c >= ar_dly) axi.arready = 1; else begin axi.arready = 0; ar_c++; end
      end else begin axi.arready = 0; ar_c = 0; end
      if (axi.rready === 1'b1) begin
        if (r_c >= r_dly) begin
          axi.rvalid = 1; axi.rlast = 1; axi.rdata_axi = slv_rdata; axi.rresp = slv_resp;
        end else begin axi.rvalid = 0; axi.rlast = 0; r_c++; end
      end else begin axi.rvalid = 0; axi.rlast = 0; r_c = 0; end
      if (axi.awvalid === 1'b1) begin
        if (aw_c >= aw_dly) axi.awready = 1; else begin axi.awready = 0; aw_c++; end
      end else begin axi.awready = 0; aw_c = 0; end
      if (axi.wvalid === 1'b1) begin
        if (w_c >= w_dly) axi.wready = 1; else begin axi.wready = 0; w_c++; end
      end else begin axi.wready = 0; w_c = 0; end
      if (axi.bready === 1'b1) begin
        if (b_c >= b_dly) begin axi.bvalid = 1; axi.bresp = slv_resp; end
        else begin axi.bvalid = 0; b_c++; end
      end else begin axi.bvalid = 0; b_c = 0; end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a handshake or completion
  initial begin
    bit p_rst, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    rsp_t r; adr_t a; wdt_t w;
    p_rst = 1; p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (refresh === 1'b1) begin
          if (rsp_q.size() == 0) chk("unexpected_refresh", cyc, 0);
          else begin
            r = rsp_q.pop_front();
            chk("refresh_cycle", cyc, r.at);
            chk("resp_err", resp_err, r.err);
            if (r.rd) chk("rdata", rdata, r.data);
          end
        end else if (resp_err !== 1'b0) chk("resp_err_without_refresh", resp_err, 0);
        if (axi.arvalid === 1'b1 && axi.arready === 1'b1) begin
          if (adr_q.size() == 0) chk("unexpected_ar", axi.araddr, 0);
          else begin
            a = adr_q.pop_front();
            chk("ar_is_read", a.wr, 0);
            chk("araddr", axi.araddr, a.addr);
            chk("arsize", axi.arsize, a.size);
            chk("arlen_arburst_arid", {axi.arlen, axi.arburst, axi.arid}, {4'd0, 2'b01, 4'd1});
          end
        end
        if (axi.awvalid === 1'b1 && axi.awready === 1'b1) begin
          if (adr_q.size() == 0) chk("unexpected_aw", axi.awaddr, 0);
          else begin
            a = adr_q.pop_front();
            chk("aw_is_write", a.wr, 1);
            chk("awaddr", axi.awaddr, a.addr);
            chk("awsize", axi.awsize, a.size);
            chk("awlen_awburst_awid", {axi.awlen, axi.awburst, axi.awid}, {4'd0, 2'b01, 4'd1});
          end
        end
        if (axi.wvalid === 1'b1 && axi.wready === 1'b1) begin
          if (wdt_q.size() == 0) chk("unexpected_w", axi.wdata, 0);
          else begin
            w = wdt_q.pop_front();
            chk("wdata", axi.wdata, w.data);
            chk("wstrb_wlast", {axi.wstrb, axi.wlast}, {w.strb, 1'b1});
          end
        end
        if (!p_rst && p_arv && !p_arr) chk("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
        if (!p_rst && p_awv && !p_awr) chk("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
        if (!p_rst && p_wv && !p_wr) chk("w_stable", {axi.wvalid, axi.wdata}, {1'b1, p_wdata});
      end
      p_rst = rst;
      p_arv = (axi.arvalid === 1'b1); p_arr = (axi.arready === 1'b1); p_araddr = axi.araddr;
      p_awv = (axi.awvalid === 1'b1); p_awr = (axi.awready === 1'b1); p_awaddr = axi.awaddr;
      p_wv = (axi.wvalid === 1'b1); p_wr = (axi.wready === 1'b1); p_wdata = axi.wdata;
    end
  end

  task automatic issue(input bit wen, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] sz);
    req_en = 1; req_wen = wen; req_sel = sel; req_addr = addr; req_wdata = wd;
    adr_q.push_back('{wen, addr, sz});
    if (wen) wdt_q.push_back('{wd, sel});
  endtask

  task automatic expect_rsp(input bit rd, input logic [31:0] d, input bit err, input int lat);
    rsp_q.push_back('{rd, d, err, cyc + lat});
  endtask

  // wait (bounded) for refresh; optionally drop req_en in the gap cycle
  task automatic wait_done(input bit drop);
    int n;
    n = 0;
    @(negedge clk);
    while (refresh !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (refresh !== 1'b1) chk("refresh_timeout", 0, 1);
    if (drop) begin
      @(posedge clk); #1; req_en = 0;
      @(negedge clk);
      chk("gap_refresh_resp_err", {refresh, resp_err}, 2'b00);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    chk("reset_refresh_err_rdata", {refresh, resp_err, rdata}, 34'd0);
    chk("reset_addr", {axi.araddr, axi.awaddr}, 64'd0);
    chk("reset_wdata_strb_size", {axi.wdata, axi.wstrb, axi.arsize, axi.awsize}, 42'd0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // word read, zero-wait
    slv_rdata = 32'hDEAD_BEEF;
    issue(0, 4'b1111, 32'h1FD0_F000, 32'h0, 3'd2);
    expect_rsp(1, 32'hDEAD_BEEF, 0, 3);
    wait_done(1);

    // byte write, awready 2 cycles after wready
    aw_dly = 2;
    issue(1, 4'b1000, 32'hBFAF_8003, 32'h1200_0000, 3'd0);
    expect_rsp(0, 32'h0, 0, 5);
    repeat (3) @(negedge clk);
    chk("w_dropped_aw_held", {axi.wvalid, axi.awvalid}, 2'b01);
    wait_done(1);
    aw_dly = 0;
    chk("rdata_held_after_write", rdata, 32'hDEAD_BEEF);

    // halfword read with slow arready and rvalid
    ar_dly = 3; r_dly = 2; slv_rdata = 32'hABCD_5678;
    issue(0, 4'b1100, 32'h1FD0_0002, 32'h0, 3'd1);
    expect_rsp(1, 32'hABCD_5678, 0, 8);
    wait_done(1);
    ar_dly = 0; r_dly = 0;

    // write with SLVERR
    slv_resp = 2'b10;
    issue(1, 4'b0011, 32'h0000_1000, 32'h0000_5A5A, 3'd1);
    expect_rsp(0, 32'h0, 1, 3);
    wait_done(1);
    slv_resp = 2'b00;

    // req_en held through the gap: second request accepted only from IDLE
    slv_rdata = 32'h0000_00AA;
    issue(0, 4'b0001, 32'h1FD0_0001, 32'h0, 3'd0);
    issue(0, 4'b0001, 32'h1FD0_0001, 32'h0, 3'd0);
    expect_rsp(1, 32'h0000_00AA, 0, 3);
    expect_rsp(1, 32'h0000_00AA, 0, 8);
    wait_done(0);
    @(negedge clk); chk("gap_no_arvalid", axi.arvalid, 0);
    @(negedge clk); chk("idle_no_arvalid", axi.arvalid, 0);
    @(negedge clk); chk("second_arvalid", axi.arvalid, 1);
    wait_done(1);

    // reset while a write is pending in WREQ
    aw_dly = 20; w_dly = 20;
    req_en = 1; req_wen = 1; req_sel = 4'b1111; req_addr = 32'h1FD0_0010; req_wdata = 32'h5555_AAAA;
    @(negedge clk); @(negedge clk);
    chk("wreq_valids_before_rst", {axi.awvalid, axi.wvalid}, 2'b11);
    @(posedge clk); #1; rst = 1; req_en = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("valids_after_rst", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    repeat (3) @(posedge clk);
    #1; aw_dly = 0; w_dly = 0;

    // read with irregular lane pattern after the reset
    slv_rdata = 32'h0BAD_F00D;
    issue(0, 4'b0101, 32'h1FD0_0004, 32'h0, 3'd2);
    expect_rsp(1, 32'h0BAD_F00D, 0, 3);
    wait_done(1);

    // write with no lanes enabled goes out as-is at word size
    issue(1, 4'b0000, 32'h1FD0_0008, 32'hCAFE_F00D, 3'd2);
    expect_rsp(0, 32'h0, 0, 3);
    wait_done(1);

    repeat (5) @(posedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("adr_q_drained", adr_q.size(), 0);
    chk("wdt_q_drained", wdt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
